// File: rtl/dual_port_ram_pkg.sv
// ============================================================================
// Module      : dual_port_ram_pkg
// Description : Shared types and the byte-lane merge helper for dual_port_ram_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dual_port_ram_pkg;

    localparam int MAX_DATA_WIDTH = 256;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Callers zero-extend to MAX_DATA_WIDTH and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] lane_en,
        input int                        lane_width
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            res[i] = lane_en[i / lane_width] ? new_word[i] : old_word[i];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dual_port_ram_if.sv
// ============================================================================
// Module      : dual_port_ram_if
// Description : Write/read port bundle for dual_port_ram_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_port_ram_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 6
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                    we;
    logic [NUM_BYTES-1:0]    wr_be;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    re;
    logic [ADDRESS_SIZE-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    modport master (
        output we, wr_be, wr_addr, wr_data, re, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  we, wr_be, wr_addr, wr_data, re, rd_addr,
        output rd_data, rd_valid
    );

endinterface

`default_nettype wire

// File: rtl/dual_port_ram_init.sv
// ============================================================================
// Module      : dual_port_ram_init
// Description : Init sequencer FSM sweeping every address after reset or clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram_init
    import dual_port_ram_pkg::*;
#(
    parameter int ADDRESS_SIZE = 6
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    clear,
    output logic                         busy,
    output logic                         init_we,
    output logic [ADDRESS_SIZE-1:0]      init_addr
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESS_SIZE-1:0] r_count;
    logic [ADDRESS_SIZE-1:0] w_count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_INIT: begin
                if (clear) begin
                    w_count_nxt = '0;
                end else if (r_count == {ADDRESS_SIZE{1'b1}}) begin
                    w_state_nxt = ST_READY;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + ADDRESS_SIZE'(1);
                end
            end
            ST_READY: begin
                if (clear) begin
                    w_state_nxt = ST_INIT;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_count_nxt = '0;
            end
        endcase
    end

    assign busy      = (r_state == ST_INIT);
    assign init_we   = busy;
    assign init_addr = r_count;

endmodule

`default_nettype wire

// File: rtl/dual_port_ram_pipe.sv
// ============================================================================
// Module      : dual_port_ram_pipe
// Description : Simple-dual-port RAM, byte-enable writes, 1/2-cycle read pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int                DATA_WIDTH   = 32,
    parameter int                BYTE_WIDTH   = 8,
    parameter int                ADDRESS_SIZE = 6,
    parameter int                RD_LATENCY   = 1,
    parameter int                RDW_MODE     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           clear,
    output logic                busy,
    dual_port_ram_if.slave      bus
);

    localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH;
    localparam int ADDRESS_DEPTH = 2 ** ADDRESS_SIZE;

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("dual_port_ram_pipe: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("dual_port_ram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0]   r_mem [ADDRESS_DEPTH];

    logic                    w_init_we;
    logic [ADDRESS_SIZE-1:0] w_init_addr;
    logic                    w_user_ok;
    logic                    w_user_we;
    logic                    w_user_re;
    logic                    w_wr_en;
    logic [ADDRESS_SIZE-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [NUM_BYTES-1:0]    w_wr_be;
    logic [DATA_WIDTH-1:0]   w_wr_word;
    logic [DATA_WIDTH-1:0]   w_rd_old;
    logic [DATA_WIDTH-1:0]   w_rd_fwd;
    logic                    w_rdw_hit;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [DATA_WIDTH-1:0]   r_stage1;
    logic                    r_vld1;

    dual_port_ram_init #(
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .busy      (busy),
        .init_we   (w_init_we),
        .init_addr (w_init_addr)
    );

    // The edge that accepts clear belongs to the sequencer, not the user.
    assign w_user_ok = ~busy & ~clear;
    assign w_user_we = w_user_ok & bus.we;
    assign w_user_re = w_user_ok & bus.re;

    assign w_wr_en   = w_init_we | (w_user_we & (|bus.wr_be));
    assign w_wr_addr = w_init_we ? w_init_addr : bus.wr_addr;
    assign w_wr_data = w_init_we ? INIT_VALUE  : bus.wr_data;
    assign w_wr_be   = w_init_we ? {NUM_BYTES{1'b1}} : bus.wr_be;

    assign w_wr_word = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(r_mem[w_wr_addr]),
                                              MAX_DATA_WIDTH'(w_wr_data),
                                              MAX_DATA_WIDTH'(w_wr_be),
                                              BYTE_WIDTH));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    assign w_rd_old  = r_mem[bus.rd_addr];
    assign w_rd_fwd  = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(w_rd_old),
                                              MAX_DATA_WIDTH'(bus.wr_data),
                                              MAX_DATA_WIDTH'(bus.wr_be),
                                              BYTE_WIDTH));
    assign w_rdw_hit = (RDW_MODE != 0) && w_user_we && (bus.wr_addr == bus.rd_addr);
    assign w_rd_word = w_rdw_hit ? w_rd_fwd : w_rd_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage1 <= '0;
            r_vld1   <= 1'b0;
        end else begin
            r_vld1 <= w_user_re;
            if (w_user_re) begin
                r_stage1 <= w_rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_stage2;
        logic                  r_vld2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage2 <= '0;
                r_vld2   <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_stage2 <= r_stage1;
                end
            end
        end

        assign bus.rd_data  = r_stage2;
        assign bus.rd_valid = r_vld2;
    end else begin : g_lat1
        assign bus.rd_data  = r_stage1;
        assign bus.rd_valid = r_vld1;
    end

endmodule

`default_nettype wire
